// File: rtl/clock_sequencer.sv
// clock_sequencer: divided slow clock with run/halt/single-step control and a debounced step button
module clock_sequencer #(
  parameter int DIV_WIDTH       = 24,
  parameter int BURST_WIDTH     = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                   CLK_IN1,
  input  logic                   rst_ni,
  input  logic                   hlt,
  input  logic                   advance_i,
  input  logic [DIV_WIDTH-1:0]   div_i,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic                   CLK_OUT1,
  output logic                   clk_en_o,
  output logic [1:0]             state_o,
  output logic [CNT_WIDTH-1:0]   cycle_cnt_o
);
  typedef enum logic [1:0] {RUN = 2'd0, STOPPING = 2'd1, HALT = 2'd2, STEP = 2'd3} state_t;
  localparam int SW = $clog2(DEBOUNCE_CYCLES + 1);
  state_t state;
  logic [DIV_WIDTH-1:0] cnt;
  logic [BURST_WIDTH-1:0] remaining;
  logic [SW-1:0] stable;
  logic sync1, sync2, deb, press;
  logic wrap, freeze, up, fall;
  assign wrap    = state != HALT && cnt >= div_i;
  // halting from a low phase must not let a pending rise slip through
  assign freeze  = state == RUN && hlt && !CLK_OUT1;
  assign up      = wrap && !CLK_OUT1 && !freeze;
  assign fall    = wrap && CLK_OUT1;
  assign state_o = state;
  always_ff @(posedge CLK_IN1 or negedge rst_ni)
    if (!rst_ni) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      deb    <= 1'b0;
      stable <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= advance_i;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == deb) stable <= '0;
      else if (stable == SW'(DEBOUNCE_CYCLES - 1)) begin
        deb    <= sync2;
        stable <= '0;
        press  <= sync2;
      end else stable <= stable + 1'b1;
    end
  always_ff @(posedge CLK_IN1 or negedge rst_ni)
    if (!rst_ni) begin
      state       <= HALT;
      cnt         <= '0;
      CLK_OUT1    <= 1'b0;
      clk_en_o    <= 1'b0;
      cycle_cnt_o <= '0;
      remaining   <= '0;
    end else begin
      cnt      <= (state == HALT || freeze || wrap) ? '0 : cnt + 1'b1;
      clk_en_o <= up;
      if (wrap && !freeze) CLK_OUT1 <= !CLK_OUT1;
      if (up) cycle_cnt_o <= cycle_cnt_o + 1'b1;
      if (up && state == STEP) remaining <= remaining - 1'b1;
      case (state)
        HALT: if (!hlt) state <= RUN;
              else if (press) begin
                state     <= STEP;
                remaining <= (burst_i == '0) ? BURST_WIDTH'(1) : burst_i;
              end
        RUN:      if (hlt) state <= (CLK_OUT1 && !fall) ? STOPPING : HALT;
        STOPPING: if (fall) state <= HALT;
        STEP:     if (fall && remaining == '0) state <= hlt ? HALT : RUN;
      endcase
    end
endmodule

// File: tb/tb_clock_sequencer.sv
// tb_clock_sequencer: scoreboard bench for run, stop, step bursts, debounce, wrap, live divider and async reset
module tb_clock_sequencer;
  logic clk = 0, rst_ni = 0, hlt = 0, advance = 0;
  logic [23:0] div = 24'd4;
  logic [7:0] burst = 8'd1;
  logic clk_out, clk_en;
  logic [1:0] state;
  logic [3:0] ccnt;
  int n_cmp = 0, n_bad = 0;
  logic [3:0] model = 0;
  logic [3:0] q[$];
  logic mon_en = 0, per_chk = 0, have_prev = 0, step_seen = 0, prev = 0, len_ok = 0;
  int cyc = 0, last_en = 0, len = 0;

  always #5 clk = ~clk;

  clock_sequencer #(.CNT_WIDTH(4)) dut (
    .CLK_IN1(clk), .rst_ni(rst_ni), .hlt(hlt), .advance_i(advance),
    .div_i(div), .burst_i(burst), .CLK_OUT1(clk_out), .clk_en_o(clk_en),
    .state_o(state), .cycle_cnt_o(ccnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int n);
    repeat (n) begin
      model++;
      q.push_back(model);
    end
  endtask

  task automatic press(input int n);
    advance = 1;
    repeat (n) tick();
    advance = 0;
  endtask

  task automatic wait_drain(input int n, input string tag);
    for (int i = 0; i < n && q.size() != 0; i++) tick();
    check(tag, q.size(), 0);
  endtask

  task automatic wait_state(input logic [1:0] s, input int n, input string tag);
    for (int i = 0; i < n && state != s; i++) tick();
    check(tag, state, s);
  endtask

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      cyc++;
      if (state == 2'd3) step_seen = 1;
      if (clk_out != prev) begin
        if (len_ok) begin
          if (prev) check("hi_width", len, div + 1);
          else check("lo_width", len >= div + 1, 1);
        end
        len_ok = 1;
        len = 1;
      end else len++;
      if ((clk_out && !prev) || clk_en) check("clk_en", clk_en, clk_out && !prev);
      if (clk_en) begin
        check("sb_pop", q.size() != 0, 1);
        if (q.size() != 0) check("cycle_cnt", ccnt, q.pop_front());
        if (per_chk && have_prev) check("period", cyc - last_en, 2 * (div + 1));
        have_prev = 1;
        last_en = cyc;
      end
      prev = clk_out;
    end
  end

  initial begin
    repeat (3) tick();
    check("rst_state", state, 2);
    check("rst_clk", clk_out, 0);
    check("rst_en", clk_en, 0);
    check("rst_cnt", ccnt, 0);
    rst_ni = 1;
    #1 check("post_rst_halt", state, 2);
    mon_en = 1;
    tick();
    check("run_entry", state, 0);
    per_chk = 1;
    have_prev = 0;
    push(3);
    wait_drain(200, "run_drain");
    check("run_cnt3", ccnt, 3);
    per_chk = 0;
    tick();
    hlt = 1;
    tick();
    check("stopping", state, 1);
    check("stopping_clk", clk_out, 1);
    for (int i = 0; i < 20 && clk_out; i++) tick();
    check("stop_fall", clk_out, 0);
    check("stop_halt", state, 2);
    hlt = 0;
    tick();
    check("resume_run", state, 0);
    repeat (2) tick();
    hlt = 1;
    tick();
    check("low_halt", state, 2);
    check("low_halt_clk", clk_out, 0);
    burst = 8'd3;
    step_seen = 0;
    push(3);
    press(20);
    wait_drain(200, "step3_drain");
    wait_state(2, 60, "step3_halt");
    check("step3_seen", step_seen, 1);
    repeat (40) tick();
    check("step3_cnt", ccnt, model);
    burst = 8'd0;
    step_seen = 0;
    push(1);
    press(20);
    wait_drain(200, "step0_drain");
    wait_state(2, 60, "step0_halt");
    check("step0_seen", step_seen, 1);
    repeat (40) tick();
    check("step0_cnt", ccnt, model);
    step_seen = 0;
    for (int i = 0; i < 20; i++) begin
      advance = ~advance;
      repeat (5) tick();
    end
    advance = 0;
    repeat (30) tick();
    check("bounce_no_step", step_seen, 0);
    check("bounce_state", state, 2);
    check("bounce_cnt", ccnt, model);
    burst = 8'd2;
    step_seen = 0;
    per_chk = 1;
    have_prev = 0;
    push(3);
    press(20);
    for (int i = 0; i < 100 && !clk_out; i++) tick();
    check("step2_first_high", clk_out, 1);
    hlt = 0;
    wait_drain(200, "step2_drain");
    check("step2_run", state, 0);
    check("step2_seen", step_seen, 1);
    step_seen = 0;
    fork press(20); join_none
    for (int i = 0; i < 6; i++) begin
      push(1);
      wait_drain(40, "run_press_drain");
    end
    check("run_press_ignored", step_seen, 0);
    check("run_press_state", state, 0);
    per_chk = 0;
    for (int i = 0; i < 20 && model != 15; i++) begin
      push(1);
      wait_drain(40, "pre_wrap_drain");
    end
    check("pre_wrap", ccnt, 15);
    push(1);
    wait_drain(40, "wrap_drain");
    check("wrap", ccnt, 0);
    hlt = 1;
    wait_state(2, 60, "div_halt");
    div = 24'd20;
    hlt = 0;
    tick();
    check("div_run", state, 0);
    repeat (10) tick();
    check("div_still_low", clk_out, 0);
    div = 24'd2;
    push(1);
    tick();
    check("div_low", clk_out, 1);
    check("div_low_en", clk_en, 1);
    mon_en = 0;
    rst_ni = 0;
    #1;
    check("async_rst_clk", clk_out, 0);
    check("async_rst_state", state, 2);
    check("async_rst_cnt", ccnt, 0);
    check("async_rst_en", clk_en, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/clock_sequencer.md
CLOCK_SEQUENCER -- requirements
Module: clock_sequencer

Interface
REQ-001 Parameter DIV_WIDTH, default 24: width of the half-period divider value.
REQ-002 Parameter BURST_WIDTH, default 8: width of the step-burst count.
REQ-003 Parameter DEBOUNCE_CYCLES, default 16: number of stable fast cycles required to accept a change on advance_i.
REQ-004 Parameter CNT_WIDTH, default 16: width of the slow-cycle counter.
REQ-005 CLK_IN1  in  1  fast system clock; all logic is on its rising edge.
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 hlt  in  1  synchronous halt request, active high.
REQ-008 advance_i  in  1  raw single-step button, asynchronous to CLK_IN1, active high.
REQ-009 div_i  in  DIV_WIDTH  half-period minus one, in fast cycles.
REQ-010 burst_i  in  BURST_WIDTH  slow cycles per advance press; 0 is treated as 1.
REQ-011 CLK_OUT1  out  1  registered slow clock.
REQ-012 clk_en_o  out  1  one-fast-cycle pulse, coincident with each CLK_OUT1 0->1 transition.
REQ-013 state_o  out  2  current state: RUN=0, STOPPING=1, HALT=2, STEP=3.
REQ-014 cycle_cnt_o  out  CNT_WIDTH  number of CLK_OUT1 rising edges since reset; wraps at 2^CNT_WIDTH.

Function
REQ-015 Divider counter: increments each fast cycle while in RUN, STOPPING or STEP; when counter >= div_i, counter <- 0 and phase toggles.
REQ-016 The >= comparison applies to live div_i, so lowering div_i mid-count ends the half-period on the next cycle, with no extended wrap.
REQ-017 Half-period = div_i+1 fast cycles; div_i=0 gives CLK_OUT1 = CLK_IN1/2.
REQ-018 CLK_OUT1 = phase register; clk_en_o is high for exactly the cycle in which phase becomes 1.
REQ-019 On each phase 0->1, cycle_cnt_o increments by 1 (modulo 2^CNT_WIDTH).
REQ-020 HALT: counter held at 0, phase held 0; hlt=0 -> RUN next cycle; debounced press with hlt=1 -> STEP, loading remaining <- (burst_i==0 ? 1 : burst_i).
REQ-021 RUN: hlt=1 with phase=0 -> HALT next cycle, counter cleared; hlt=1 with phase=1 -> STOPPING.
REQ-022 STOPPING: counts normally; on the phase 1->0 toggle -> HALT; hlt deasserted here does not abort the stop.
REQ-023 STEP: each phase 0->1 decrements remaining; on the phase 1->0 toggle with remaining==0 -> HALT if hlt=1, else RUN.
REQ-024 STEP always completes its full burst; hlt changes and additional presses during STEP are ignored.
REQ-025 CLK_OUT1 never produces a high or low pulse shorter than div_i+1 fast cycles (no runt pulses on halt, step or resume).
REQ-026 Presses are accepted only in HALT; presses in RUN or STOPPING are discarded, not queued.
REQ-027 advance_i passes a 2-flop synchroniser; the debounced level updates only after the synchronised value differs from it for DEBOUNCE_CYCLES consecutive cycles; a press = debounced 0->1.
REQ-028 Any bounce shorter than DEBOUNCE_CYCLES restarts the stability count and produces no press.

Reset
REQ-029 rst_ni low asynchronously forces state=HALT, CLK_OUT1=0, clk_en_o=0, cycle_cnt_o=0, divider counter=0, remaining=0, synchroniser and debounced level=0, stability count=0.
REQ-030 Reset asserted mid-cycle (CLK_OUT1 high) drops CLK_OUT1 immediately; this is the only permitted short pulse.
REQ-031 After rst_ni rises, the first state change occurs on the next CLK_IN1 edge per REQ-020.

Verification
REQ-032 div_i=4, hlt=0 after reset -> HALT for 1 cycle, then RUN; CLK_OUT1 period 10 fast cycles, 5 high/5 low; clk_en_o pulses 1 cycle per period; cycle_cnt_o=3 after 3 rising edges.
REQ-033 div_i=4, hlt raised 2 cycles into a high phase -> STOPPING, CLK_OUT1 stays high 3 more cycles, falls, then HALT with CLK_OUT1=0; hlt raised during low phase -> HALT next cycle.
REQ-034 HALT, burst_i=3, clean press held >DEBOUNCE_CYCLES+2 -> exactly 3 CLK_OUT1 pulses, then HALT; cycle_cnt_o +3; burst_i=0 -> exactly 1 pulse.
REQ-035 advance_i bounce toggling every 5 cycles for 100 cycles, DEBOUNCE_CYCLES=16 -> no STEP entry, no CLK_OUT1 edge.
REQ-036 STEP with burst_i=2, hlt dropped during first pulse -> both pulses complete, then RUN without a gap or runt pulse; press during RUN -> ignored.
REQ-037 cycle_cnt_o at 2^CNT_WIDTH-1 plus one rising edge -> 0; div_i lowered from 20 to 2 at counter=10 -> toggle on the next cycle.
